// File: rtl/usb_desc_pkg.sv
// USB standard descriptor constants shared by the EP0 control path.
package usb_desc_pkg;

   // wValue high byte of GET_DESCRIPTOR
   localparam logic [7:0] DESC_TYPE_DEVICE        = 8'd1;
   localparam logic [7:0] DESC_TYPE_CONFIGURATION = 8'd2;
   localparam logic [7:0] DESC_TYPE_STRING        = 8'd3;

   // Byte offset of wTotalLength inside a configuration descriptor
   localparam int unsigned DESC_CFG_TOTAL_LEN_OFS = 2;

endpackage

// File: rtl/usb_ep_pkg.sv
// EP0 endpoint-side types: descriptor streamer state and small helpers.
package usb_ep_pkg;

   typedef enum logic [2:0] {
      EP0_IDLE   = 3'd0,
      EP0_LOOKUP = 3'd1,
      EP0_LEN_LO = 3'd2,
      EP0_LEN_HI = 3'd3,
      EP0_STREAM = 3'd4,
      EP0_ERR    = 3'd5
   } ep0_desc_state_e;

   // Unsigned 16-bit minimum, used to clip the transfer to wLength
   function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ep0_desc_addr_lut.sv
// Combinational decode of descriptor type/index into a ROM start address
// using the packed start-index LUT. Entries: configurations first, then
// string descriptor zero (language IDs), then the remaining strings.
module ep0_desc_addr_lut
   import usb_desc_pkg::*;
#(
   parameter int ROM_IDX_WID   = 9,
   parameter int NUM_CONFIGS   = 1,
   parameter int NUM_STR_DESCS = 0,
   parameter int LUT_WID       = ROM_IDX_WID*(NUM_CONFIGS+1+NUM_STR_DESCS)
)(
   input  logic [7:0]             i_desc_type,
   input  logic [7:0]             i_desc_idx,
   input  logic [LUT_WID-1:0]     i_lut,
   output logic [ROM_IDX_WID-1:0] o_start,
   output logic                   o_valid,
   output logic                   o_is_cfg
);

   // Select the LUT entry matching the request; unsupported requests stay invalid
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      o_start  = '0;
      o_valid  = 1'b0;
      o_is_cfg = 1'b0;
      case (i_desc_type)
         DESC_TYPE_DEVICE: begin
            // The device descriptor always sits at ROM address 0
            o_valid = 1'b1;
         end
         DESC_TYPE_CONFIGURATION: begin
            o_is_cfg = 1'b1;
            for (int i = 0; i < NUM_CONFIGS; i++) begin
               if (i_desc_idx == 8'(i)) begin
                  o_start = i_lut[i*ROM_IDX_WID +: ROM_IDX_WID];
                  o_valid = 1'b1;
               end
            end
         end
         DESC_TYPE_STRING: begin
            // With no string descriptors configured, every string request stalls
            for (int i = 0; i <= NUM_STR_DESCS; i++) begin
               if (i_desc_idx == 8'(i)) begin
                  o_start = i_lut[(NUM_CONFIGS+i)*ROM_IDX_WID +: ROM_IDX_WID];
                  o_valid = (NUM_STR_DESCS != 0);
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ep0_desc_streamer.sv
// EP0 GET_DESCRIPTOR streamer: resolves the descriptor start address,
// reads its length from ROM and streams min(wLength, length) bytes with
// last-byte and packet-end markers.
// Optional feature macro: EP0_DESC_ZLP_EN -- when defined, zlpReq_o pulses
// after a transfer that ended on a full packet short of wLength.
module ep0_desc_streamer
   import usb_desc_pkg::*;
   import usb_ep_pkg::*;
#(
   parameter int ROM_IDX_WID   = 9,
   parameter int NUM_CONFIGS   = 1,
   parameter int NUM_STR_DESCS = 0,
   parameter int LUT_WID       = ROM_IDX_WID*(NUM_CONFIGS+1+NUM_STR_DESCS),
   parameter int EP0_MAX_PKT   = 64
)(
   input  logic                   clk12_i,
   input  logic                   rst_i,
   input  logic                   abort_i,
   input  logic                   reqValid_i,
   output logic                   reqReady_o,
   input  logic [7:0]             reqDescType_i,
   input  logic [7:0]             reqDescIdx_i,
   input  logic [15:0]            reqLength_i,
   output logic                   reqErr_o,
   output logic [ROM_IDX_WID-1:0] romAddr_o,
   input  logic [7:0]             romData_i,
   input  logic [LUT_WID-1:0]     descStartIdx_i,
   output logic [7:0]             data_o,
   output logic                   dataValid_o,
   input  logic                   dataReady_i,
   output logic                   dataLast_o,
   output logic                   packetEnd_o,
   output logic                   zlpReq_o
);

   localparam int                     PKT_WID  = $clog2(EP0_MAX_PKT);
   localparam logic [PKT_WID-1:0]     PKT_LAST = PKT_WID'(EP0_MAX_PKT-1);
   localparam logic [PKT_WID-1:0]     PKT_ONE  = PKT_WID'(1);
   localparam logic [ROM_IDX_WID-1:0] ADDR_ONE = ROM_IDX_WID'(1);
   localparam logic [ROM_IDX_WID-1:0] CFG_OFS  = ROM_IDX_WID'(DESC_CFG_TOTAL_LEN_OFS);

   ep0_desc_state_e        r_state;
   ep0_desc_state_e        w_state_nxt;

   logic [7:0]             r_req_type;
   logic [7:0]             r_req_idx;
   logic [15:0]            r_req_len;
   logic [ROM_IDX_WID-1:0] r_start;
   logic [ROM_IDX_WID-1:0] r_rom_addr;
   logic [7:0]             r_len_lo;
   logic [15:0]            r_remaining;
   logic [PKT_WID-1:0]     r_pkt_cnt;

   logic [ROM_IDX_WID-1:0] w_lut_start;
   logic                   w_lut_valid;
   logic                   w_lut_is_cfg;
   logic [15:0]            w_desc_len;
   logic [15:0]            w_xfer_len;
   logic                   w_stream_load;
   logic                   w_last_hs;

   ep0_desc_addr_lut #(
      .ROM_IDX_WID   (ROM_IDX_WID),
      .NUM_CONFIGS   (NUM_CONFIGS),
      .NUM_STR_DESCS (NUM_STR_DESCS),
      .LUT_WID       (LUT_WID)
   ) u_addr_lut (
      .i_desc_type (r_req_type),
      .i_desc_idx  (r_req_idx),
      .i_lut       (descStartIdx_i),
      .o_start     (w_lut_start),
      .o_valid     (w_lut_valid),
      .o_is_cfg    (w_lut_is_cfg)
   );

   // Descriptor length: bLength alone, or wTotalLength assembled in LEN_HI
   assign w_desc_len    = (r_state == EP0_LEN_HI) ? {romData_i, r_len_lo} : {8'h00, romData_i};
   assign w_xfer_len    = min_u16(r_req_len, w_desc_len);
   assign w_stream_load = ((r_state == EP0_LEN_LO) && !w_lut_is_cfg) || (r_state == EP0_LEN_HI);
   assign w_last_hs     = (r_state == EP0_STREAM) && dataReady_i && (r_remaining == 16'd1);
   assign romAddr_o     = r_rom_addr;

   // State register
   always_ff @(posedge clk12_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) r_state <= EP0_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode; abort overrides everything, including a new request
   always_comb begin
      w_state_nxt = r_state;
      if (abort_i) begin
         w_state_nxt = EP0_IDLE;
      end else begin
         case (r_state)
            EP0_IDLE:   if (reqValid_i) w_state_nxt = EP0_LOOKUP;
            EP0_LOOKUP: w_state_nxt = w_lut_valid ? EP0_LEN_LO : EP0_ERR;
            EP0_LEN_LO: begin
               if (w_lut_is_cfg)            w_state_nxt = EP0_LEN_HI;
               else if (w_xfer_len == '0)   w_state_nxt = EP0_IDLE;
               else                         w_state_nxt = EP0_STREAM;
            end
            EP0_LEN_HI: w_state_nxt = (w_xfer_len == '0) ? EP0_IDLE : EP0_STREAM;
            EP0_STREAM: if (w_last_hs) w_state_nxt = EP0_IDLE;
            EP0_ERR:    w_state_nxt = EP0_IDLE;
            default:    w_state_nxt = EP0_IDLE;
         endcase
      end
   end

   // Request latch, ROM address sequencing and transfer counters
   always_ff @(posedge clk12_i) begin
      if (rst_i) begin
         r_req_type  <= '0;
         r_req_idx   <= '0;
         r_req_len   <= '0;
         r_start     <= '0;
         r_rom_addr  <= '0;
         r_len_lo    <= '0;
         r_remaining <= '0;
         r_pkt_cnt   <= '0;
      end else if (abort_i) begin
         r_rom_addr  <= '0;
         r_remaining <= '0;
         r_pkt_cnt   <= '0;
      end else begin
         case (r_state)
            EP0_IDLE: begin
               if (reqValid_i) begin
                  r_req_type <= reqDescType_i;
                  r_req_idx  <= reqDescIdx_i;
                  r_req_len  <= reqLength_i;
               end
            end
            EP0_LOOKUP: begin
               // Configurations read wTotalLength first; others read bLength at the start
               r_start    <= w_lut_start;
               r_rom_addr <= w_lut_is_cfg ? (w_lut_start + CFG_OFS) : w_lut_start;
            end
            EP0_LEN_LO: begin
               r_len_lo <= romData_i;
               if (w_lut_is_cfg) r_rom_addr <= r_rom_addr + ADDR_ONE;
            end
            EP0_STREAM: begin
               if (dataReady_i) begin
                  r_rom_addr  <= r_rom_addr + ADDR_ONE;
                  r_remaining <= r_remaining - 16'd1;
                  r_pkt_cnt   <= r_pkt_cnt + PKT_ONE;
               end
            end
            default: ;
         endcase
         // Entering STREAM: rewind to the descriptor start and load the clipped count
         if (w_stream_load) begin
            r_rom_addr  <= r_start;
            r_remaining <= w_xfer_len;
            r_pkt_cnt   <= '0;
         end
      end
   end

`ifdef EP0_DESC_ZLP_EN
   logic r_short;
   logic r_zlp;

   // Track whether the host asked for more than the descriptor holds and
   // flag a zero-length packet when the final packet was exactly full
   always_ff @(posedge clk12_i) begin
      if (rst_i || abort_i) begin
         r_short <= 1'b0;
         r_zlp   <= 1'b0;
      end else begin
         r_zlp <= w_last_hs && (r_pkt_cnt == PKT_LAST) && r_short;
         if (w_stream_load) r_short <= (w_desc_len < r_req_len);
      end
   end

   assign zlpReq_o = r_zlp;
`else
   assign zlpReq_o = 1'b0;
`endif

   // Moore-style outputs decoded from the state and stream counters
   always_comb begin
      reqReady_o  = (r_state == EP0_IDLE);
      reqErr_o    = (r_state == EP0_ERR);
      dataValid_o = (r_state == EP0_STREAM);
      data_o      = (r_state == EP0_STREAM) ? romData_i : 8'h00;
      dataLast_o  = (r_state == EP0_STREAM) && (r_remaining == 16'd1);
      packetEnd_o = dataLast_o || ((r_state == EP0_STREAM) && (r_pkt_cnt == PKT_LAST));
   end

endmodule

// File: tb/tb_ep0_desc_streamer.sv
// Directed, table-driven bench for ep0_desc_streamer with a behavioural ROM.
module tb_ep0_desc_streamer;

   localparam int ROM_IDX_WID   = 9;
   localparam int NUM_CONFIGS   = 2;
   localparam int NUM_STR_DESCS = 1;
   localparam int LUT_WID       = ROM_IDX_WID*(NUM_CONFIGS+1+NUM_STR_DESCS);
   localparam int EP0_MAX_PKT   = 64;
   localparam int BUDGET        = 600;
`ifdef EP0_DESC_ZLP_EN
   localparam int ZLP_ON = 1;
`else
   localparam int ZLP_ON = 0;
`endif

   typedef struct {
      logic [7:0]  typ;
      logic [7:0]  idx;
      logic [15:0] wlen;
      int          exp_bytes;
      int          exp_lat;
      int          exp_err;
      logic [8:0]  exp_start;
      int          exp_zlp;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   abort = 1'b0;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic [7:0]             req_type = '0;
   logic [7:0]             req_idx = '0;
   logic [15:0]            req_len = '0;
   logic                   req_err;
   logic [ROM_IDX_WID-1:0] rom_addr;
   logic [7:0]             rom_data;
   logic [LUT_WID-1:0]     lut;
   logic [7:0]             data;
   logic                   data_valid;
   logic                   data_ready = 1'b0;
   logic                   data_last;
   logic                   packet_end;
   logic                   zlp_req;

   logic [7:0] rom [512];
   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs [12];

   // Config 0 at 32, config 1 at 96, string 0 at 200, string 1 at 210
   assign lut      = {9'd210, 9'd200, 9'd96, 9'd32};
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   ep0_desc_streamer #(
      .ROM_IDX_WID   (ROM_IDX_WID),
      .NUM_CONFIGS   (NUM_CONFIGS),
      .NUM_STR_DESCS (NUM_STR_DESCS),
      .LUT_WID       (LUT_WID),
      .EP0_MAX_PKT   (EP0_MAX_PKT)
   ) dut (
      .clk12_i        (clk),
      .rst_i          (rst),
      .abort_i        (abort),
      .reqValid_i     (req_valid),
      .reqReady_o     (req_ready),
      .reqDescType_i  (req_type),
      .reqDescIdx_i   (req_idx),
      .reqLength_i    (req_len),
      .reqErr_o       (req_err),
      .romAddr_o      (rom_addr),
      .romData_i      (rom_data),
      .descStartIdx_i (lut),
      .data_o         (data),
      .dataValid_o    (data_valid),
      .dataReady_i    (data_ready),
      .dataLast_o     (data_last),
      .packetEnd_o    (packet_end),
      .zlpReq_o       (zlp_req)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request, then observe every cycle at the falling edge until IDLE.
   // abort_at >= 0 aborts instead of accepting that byte (0-based count).
   task automatic run_xfer(input string tag, input vec_t v, input bit rand_ready, input int abort_at);
      int         cyc = 0;
      int         nbytes = 0;
      int         lat = -1;
      int         errs = 0;
      int         zlps = 0;
      bit         done = 1'b0;
      bit         aborted = 1'b0;
      bit         prev_stall = 1'b0;
      bit         rdy;
      logic [7:0] prev_data = '0;
      logic       prev_last = 1'b0;
      logic       prev_pe = 1'b0;
      logic [8:0] a;
      @(negedge clk);
      check({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
      req_type   = v.typ;
      req_idx    = v.idx;
      req_len    = v.wlen;
      req_valid  = 1'b1;
      data_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 1;
      while (!done) begin
         if (req_err) errs++;
         if (zlp_req) zlps++;
         if (data_valid) begin
            if (lat < 0) lat = cyc;
            if (prev_stall) begin
               check({tag, " stall_data"}, 32'(data), 32'(prev_data));
               check({tag, " stall_last"}, 32'(data_last), 32'(prev_last));
               check({tag, " stall_pkt_end"}, 32'(packet_end), 32'(prev_pe));
            end
            if (abort_at >= 0 && nbytes == abort_at) begin
               abort      = 1'b1;
               data_ready = 1'b0;
               @(negedge clk);
               abort = 1'b0;
               check({tag, " abort_valid"}, 32'(data_valid), 32'd0);
               check({tag, " abort_idle"}, 32'(req_ready), 32'd1);
               check({tag, " abort_bytes"}, 32'(nbytes), 32'(abort_at));
               aborted = 1'b1;
               done    = 1'b1;
            end else begin
               rdy = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
               data_ready = rdy;
               if (rdy) begin
                  a = v.exp_start + 9'(nbytes);
                  check({tag, " data"}, 32'(data), 32'(rom[a]));
                  check({tag, " last"}, 32'(data_last), 32'(nbytes + 1 == v.exp_bytes));
                  check({tag, " pkt_end"}, 32'(packet_end),
                        32'((nbytes + 1 == v.exp_bytes) || (nbytes % EP0_MAX_PKT == EP0_MAX_PKT - 1)));
                  nbytes++;
               end
               prev_stall = !rdy;
               prev_data  = data;
               prev_last  = data_last;
               prev_pe    = packet_end;
            end
         end else begin
            prev_stall = 1'b0;
            data_ready = 1'b1;
            if (req_ready) done = 1'b1;
         end
         if (!done) begin
            if (cyc >= BUDGET) begin
               check({tag, " timeout"}, 32'd0, 32'd1);
               done = 1'b1;
            end else begin
               @(negedge clk);
               cyc++;
            end
         end
      end
      if (!aborted) begin
         check({tag, " byte_count"}, 32'(nbytes), 32'(v.exp_bytes));
         check({tag, " err_pulses"}, 32'(errs), 32'(v.exp_err));
         check({tag, " zlp_pulses"}, 32'(zlps), 32'(v.exp_zlp));
         if (v.exp_bytes > 0) check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      end
   endtask

   initial begin
      bit saw_valid;
      int saw_err;

      for (int i = 0; i < 512; i++) rom[i] = 8'((i * 7 + 3) & 255);
      rom[0]   = 8'd18; rom[1]   = 8'd1;
      rom[32]  = 8'd9;  rom[33]  = 8'd2; rom[34] = 8'd32; rom[35] = 8'd0;
      rom[96]  = 8'd9;  rom[97]  = 8'd2; rom[98] = 8'd64; rom[99] = 8'd0;
      rom[200] = 8'd4;  rom[201] = 8'd3;
      rom[210] = 8'd10; rom[211] = 8'd3;

      //          typ    idx    wlen      bytes lat err start     zlp
      vecs[0]  = '{8'd1, 8'd0, 16'd64,   18,   3,  0,  9'd0,   0};
      vecs[1]  = '{8'd2, 8'd0, 16'd9,    9,    4,  0,  9'd32,  0};
      vecs[2]  = '{8'd3, 8'd2, 16'd64,   0,    0,  1,  9'd0,   0};
      vecs[3]  = '{8'd1, 8'd0, 16'd64,   18,   3,  0,  9'd0,   0};
      vecs[4]  = '{8'd2, 8'd1, 16'd255,  64,   4,  0,  9'd96,  ZLP_ON};
      vecs[5]  = '{8'd3, 8'd0, 16'd255,  4,    3,  0,  9'd200, 0};
      vecs[6]  = '{8'd3, 8'd1, 16'd10,   10,   3,  0,  9'd210, 0};
      vecs[7]  = '{8'd1, 8'd0, 16'd0,    0,    0,  0,  9'd0,   0};
      vecs[8]  = '{8'd2, 8'd2, 16'd64,   0,    0,  1,  9'd0,   0};
      vecs[9]  = '{8'd6, 8'd0, 16'd64,   0,    0,  1,  9'd0,   0};
      vecs[10] = '{8'd2, 8'd1, 16'd64,   64,   4,  0,  9'd96,  0};
      vecs[11] = '{8'd1, 8'd5, 16'd8,    8,    3,  0,  9'd0,   0};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst rom_addr", 32'(rom_addr), 32'd0);
      check("rst data_valid", 32'(data_valid), 32'd0);
      check("rst req_err", 32'(req_err), 32'd0);
      check("rst data_last", 32'(data_last), 32'd0);
      check("rst packet_end", 32'(packet_end), 32'd0);
      check("rst zlp_req", 32'(zlp_req), 32'd0);
      check("rst data", 32'(data), 32'd0);

      // Table-driven transfers with ready held high
      for (int i = 0; i < 12; i++) run_xfer($sformatf("vec%0d", i), vecs[i], 1'b0, -1);

      // Back-pressure: same byte sequence, stable outputs while stalled
      run_xfer("bp_device", vecs[0], 1'b1, -1);
      run_xfer("bp_cfg1", vecs[4], 1'b1, -1);
      run_xfer("bp_cfg0", vecs[1], 1'b1, -1);

      // Abort after byte 5 of 18, then a fresh request starts at ROM address 0
      run_xfer("abort", vecs[0], 1'b0, 5);
      run_xfer("after_abort", vecs[0], 1'b0, -1);

      // Abort coincident with a request: the request must not be accepted
      @(negedge clk);
      abort     = 1'b1;
      req_type  = 8'd1;
      req_idx   = 8'd0;
      req_len   = 16'd64;
      req_valid = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      req_valid = 1'b0;
      check("abort_prio idle", 32'(req_ready), 32'd1);
      saw_valid = 1'b0;
      saw_err   = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (data_valid) saw_valid = 1'b1;
         if (req_err) saw_err++;
      end
      check("abort_prio no_data", 32'(saw_valid), 32'd0);
      check("abort_prio no_err", 32'(saw_err), 32'd0);
      check("abort_prio still_idle", 32'(req_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
